// File: rtl/game_pkg.sv
// Shared types and constants for the game control path: FSM state encoding,
// strobe decoding and the watchdog fault flag layout.
package game_pkg;

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_IDLE      = 4'd1,
    S_GEN_MOVE  = 4'd2,
    S_CHECK     = 4'd3,
    S_APPLY     = 4'd4,
    S_MOVE_E    = 4'd5,
    S_DRAW_MAP  = 4'd6,
    S_DRAW_LINK = 4'd7,
    S_DRAW_E    = 4'd8
  } state_e;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  localparam int unsigned TE_MAP   = 0;
  localparam int unsigned TE_LINK  = 1;
  localparam int unsigned TE_ENEMY = 2;

  localparam int unsigned WD_W        = 20;
  localparam int unsigned NUM_STROBES = 9;

  // One-hot strobe vector, bit order {draw_e, draw_link, draw_map, move_e,
  // apply, check, gen_move, idle, init}; unknown encodings decode as INIT.
  function automatic logic [NUM_STROBES-1:0] strobe_of(input state_e s);
    logic [NUM_STROBES-1:0] v;
    v = '0;
    case (s)
      S_INIT:      v[0] = ON;
      S_IDLE:      v[1] = ON;
      S_GEN_MOVE:  v[2] = ON;
      S_CHECK:     v[3] = ON;
      S_APPLY:     v[4] = ON;
      S_MOVE_E:    v[5] = ON;
      S_DRAW_MAP:  v[6] = ON;
      S_DRAW_LINK: v[7] = ON;
      S_DRAW_E:    v[8] = ON;
      default:     v[0] = ON;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/frame_sequencer_draw_watchdog.sv
// Cycle counter shared by the three draw states. It holds at zero outside a
// draw state and clears whenever the sequencer advances, so every draw state
// starts counting from zero on its entry cycle.
module draw_watchdog
  import game_pkg::*;
#(
  parameter logic [WD_W-1:0] LIMIT = 20'd131071
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            active_i,
  input  logic            clear_i,
  output logic [WD_W-1:0] cnt_o,
  output logic            timeout_o
);

  logic [WD_W-1:0] cnt_q, cnt_d;

  // Next count: clear on leave/advance, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (!active_i || clear_i) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + WD_W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign timeout_o = active_i && (cnt_q >= (LIMIT - WD_W'(1)));

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame control FSM for the game datapath: init, idle wait, the four
// single-cycle logic steps and three watchdog-guarded draw states. Strobes
// are registered one-hot outputs; frame count and sticky draw faults are
// exported for debug display.
module frame_sequencer
  import game_pkg::*;
#(
  parameter int unsigned     INIT_CYCLES  = 4,
  parameter logic [WD_W-1:0] DRAW_TIMEOUT = 20'd131071,
  parameter int unsigned     FC_W         = 8
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            pause,
  input  logic            idle_done,
  input  logic            draw_map_done,
  input  logic            draw_link_done,
  input  logic            draw_enemies_done,
  output logic            init,
  output logic            idle,
  output logic            gen_move,
  output logic            check_collide,
  output logic            apply_act_link,
  output logic            move_enemies,
  output logic            draw_map,
  output logic            draw_link,
  output logic            draw_enemies,
  output logic [FC_W-1:0] frame_count,
  output logic [2:0]      timeout_err
);

  localparam int unsigned     IC_W      = $clog2(INIT_CYCLES + 1);
  localparam logic [IC_W-1:0] INIT_LAST = IC_W'(INIT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [IC_W-1:0]        init_cnt_q;
  logic [NUM_STROBES-1:0] strobe_q;
  logic [FC_W-1:0]        frame_count_q;
  logic [2:0]             timeout_err_q;

  logic            in_draw, done_sel, sampled, adv, wd_timeout;
  logic [2:0]      err_mask;
  logic [WD_W-1:0] wd_cnt;

  draw_watchdog #(
    .LIMIT(DRAW_TIMEOUT)
  ) u_wd (
    .clk_i    (clock),
    .rst_ni   (resetn),
    .active_i (in_draw),
    .clear_i  (adv),
    .cnt_o    (wd_cnt),
    .timeout_o(wd_timeout)
  );

  // Select the done flag and fault bit of the current draw state. A done is
  // only honoured from the second cycle on, so a level left over from the
  // previous engine cannot skip the entry cycle.
  always_comb begin
    in_draw  = OFF;
    done_sel = OFF;
    err_mask = '0;
    case (state_q)
      S_DRAW_MAP: begin
        in_draw            = ON;
        done_sel           = draw_map_done;
        err_mask[TE_MAP]   = ON;
      end
      S_DRAW_LINK: begin
        in_draw            = ON;
        done_sel           = draw_link_done;
        err_mask[TE_LINK]  = ON;
      end
      S_DRAW_E: begin
        in_draw            = ON;
        done_sel           = draw_enemies_done;
        err_mask[TE_ENEMY] = ON;
      end
      default: ;
    endcase
    sampled = in_draw && (wd_cnt != '0) && done_sel;
    adv     = sampled || wd_timeout;
  end

  // Next-state selection; any unknown encoding falls back to INIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:      if (init_cnt_q >= INIT_LAST) state_d = S_DRAW_MAP;
      S_IDLE:      if (idle_done && !pause) state_d = S_GEN_MOVE;
      S_GEN_MOVE:  state_d = S_CHECK;
      S_CHECK:     state_d = S_APPLY;
      S_APPLY:     state_d = S_MOVE_E;
      S_MOVE_E:    state_d = S_DRAW_MAP;
      S_DRAW_MAP:  if (adv) state_d = S_DRAW_LINK;
      S_DRAW_LINK: if (adv) state_d = S_DRAW_E;
      S_DRAW_E:    if (adv) state_d = S_IDLE;
      default:     state_d = S_INIT;
    endcase
  end

  // State, registered strobes, init hold counter, frame counter, fault flags.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= S_INIT;
      strobe_q      <= strobe_of(S_INIT);
      init_cnt_q    <= '0;
      frame_count_q <= '0;
      timeout_err_q <= '0;
    end else begin
      state_q  <= state_d;
      strobe_q <= strobe_of(state_d);
      if (state_q == S_INIT) begin
        init_cnt_q <= init_cnt_q + IC_W'(1);
      end else begin
        init_cnt_q <= '0;
      end
      if (state_q == S_DRAW_E && adv) begin
        frame_count_q <= frame_count_q + FC_W'(1);
      end
      if (wd_timeout && !sampled) begin
        timeout_err_q <= timeout_err_q | err_mask;
      end
    end
  end

  assign {draw_enemies, draw_link, draw_map, move_enemies, apply_act_link,
          check_collide, gen_move, idle, init} = strobe_q;
  assign frame_count = frame_count_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with INIT_CYCLES=4, DRAW_TIMEOUT=16.
module tb_frame_sequencer;

  logic       clock = 1'b0;
  logic       resetn, pause, idle_done;
  logic [2:0] dn;
  logic       init, idle, gen_move, check_collide, apply_act_link;
  logic       move_enemies, draw_map, draw_link, draw_enemies;
  logic [7:0] frame_count;
  logic [2:0] timeout_err;
  logic [8:0] strobes;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  localparam logic [8:0] X_INIT = 9'h001;
  localparam logic [8:0] X_IDLE = 9'h002;
  localparam logic [8:0] X_GEN  = 9'h004;
  localparam logic [8:0] X_CHK  = 9'h008;
  localparam logic [8:0] X_APP  = 9'h010;
  localparam logic [8:0] X_MOV  = 9'h020;
  localparam logic [8:0] X_MAP  = 9'h040;
  localparam logic [8:0] X_LINK = 9'h080;
  localparam logic [8:0] X_EN   = 9'h100;

  frame_sequencer #(
    .INIT_CYCLES (4),
    .DRAW_TIMEOUT(20'd16),
    .FC_W        (8)
  ) dut (
    .clock            (clock),
    .resetn           (resetn),
    .pause            (pause),
    .idle_done        (idle_done),
    .draw_map_done    (dn[0]),
    .draw_link_done   (dn[1]),
    .draw_enemies_done(dn[2]),
    .init             (init),
    .idle             (idle),
    .gen_move         (gen_move),
    .check_collide    (check_collide),
    .apply_act_link   (apply_act_link),
    .move_enemies     (move_enemies),
    .draw_map         (draw_map),
    .draw_link        (draw_link),
    .draw_enemies     (draw_enemies),
    .frame_count      (frame_count),
    .timeout_err      (timeout_err)
  );

  assign strobes = {draw_enemies, draw_link, draw_map, move_enemies,
                    apply_act_link, check_collide, gen_move, idle, init};

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Draw state answered one cycle after its enable: two cycles total.
  task automatic draw_step(input int idx, input logic [8:0] exp);
    check("draw_entry", 32'(strobes), 32'(exp));
    tick();
    check("draw_hold", 32'(strobes), 32'(exp));
    dn[idx] = 1'b1;
    tick();
    dn[idx] = 1'b0;
  endtask

  // Draw state whose done never comes: exactly 16 cycles.
  task automatic timeout_draw(input logic [8:0] exp);
    for (int i = 0; i < 16; i++) begin
      check("to_hold", 32'(strobes), 32'(exp));
      tick();
    end
  endtask

  task automatic logic_steps();
    idle_done = 1'b1;
    tick();
    idle_done = 1'b0;
    check("gen", 32'(strobes), 32'(X_GEN));
    tick();
    check("chk", 32'(strobes), 32'(X_CHK));
    tick();
    check("app", 32'(strobes), 32'(X_APP));
    tick();
    check("mov", 32'(strobes), 32'(X_MOV));
    tick();
  endtask

  task automatic run_frame();
    logic_steps();
    draw_step(0, X_MAP);
    draw_step(1, X_LINK);
    draw_step(2, X_EN);
    check("frame_idle", 32'(strobes), 32'(X_IDLE));
  endtask

  task automatic init_seq();
    for (int i = 0; i < 4; i++) begin
      check("init_hold", 32'(strobes), 32'(X_INIT));
      tick();
    end
  endtask

  // Exactly one strobe in every cycle after the first reset edge.
  always @(negedge clock) begin
    if (mon_en) check("onehot", 32'($countones(strobes)), 32'd1);
  end

  initial begin
    #2000000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; pause = 1'b0; idle_done = 1'b0; dn = '0;
    tick();
    mon_en = 1'b1;
    tick();
    check("rst_strobe", 32'(strobes), 32'(X_INIT));
    check("rst_fc", 32'(frame_count), 32'd0);
    check("rst_te", 32'(timeout_err), 32'd0);

    // First frame after init paints the screen directly.
    resetn = 1'b1;
    init_seq();
    draw_step(0, X_MAP);
    draw_step(1, X_LINK);
    draw_step(2, X_EN);
    check("f1_idle", 32'(strobes), 32'(X_IDLE));
    check("f1_fc", 32'(frame_count), 32'd1);

    run_frame();
    check("f2_fc", 32'(frame_count), 32'd2);

    // Link done held high from entry: entry cycle must not advance.
    logic_steps();
    draw_step(0, X_MAP);
    dn[1] = 1'b1;
    check("link_entry", 32'(strobes), 32'(X_LINK));
    tick();
    check("link_held", 32'(strobes), 32'(X_LINK));
    tick();
    dn[1] = 1'b0;
    draw_step(2, X_EN);
    check("f3_idle", 32'(strobes), 32'(X_IDLE));
    check("f3_fc", 32'(frame_count), 32'd3);

    // Pause drops idle_done; stray dones in IDLE are ignored.
    pause = 1'b1;
    dn = 3'b111;
    for (int i = 0; i < 5; i++) begin
      idle_done = 1'b1;
      tick();
      idle_done = 1'b0;
      check("pause_idle", 32'(strobes), 32'(X_IDLE));
      tick();
    end
    dn = '0;
    check("pause_fc", 32'(frame_count), 32'd3);
    pause = 1'b0;
    run_frame();
    check("f4_fc", 32'(frame_count), 32'd4);

    // Map engine hangs.
    logic_steps();
    timeout_draw(X_MAP);
    draw_step(1, X_LINK);
    draw_step(2, X_EN);
    check("mapto_idle", 32'(strobes), 32'(X_IDLE));
    check("mapto_te", 32'(timeout_err), 32'b001);
    check("f5_fc", 32'(frame_count), 32'd5);
    run_frame();
    run_frame();
    check("f7_fc", 32'(frame_count), 32'd7);

    // Reset in the middle of DRAW_MAP.
    logic_steps();
    check("pre_rst_map", 32'(strobes), 32'(X_MAP));
    resetn = 1'b0;
    tick();
    check("mid_rst_strobe", 32'(strobes), 32'(X_INIT));
    check("mid_rst_fc", 32'(frame_count), 32'd0);
    check("mid_rst_te", 32'(timeout_err), 32'd0);
    resetn = 1'b1;
    init_seq();
    draw_step(0, X_MAP);
    draw_step(1, X_LINK);
    draw_step(2, X_EN);
    check("r1_fc", 32'(frame_count), 32'd1);

    // Done arrives in the timeout cycle: advance without fault.
    logic_steps();
    for (int i = 0; i < 15; i++) begin
      check("tie_hold", 32'(strobes), 32'(X_MAP));
      tick();
    end
    dn[0] = 1'b1;
    check("tie_last", 32'(strobes), 32'(X_MAP));
    tick();
    dn[0] = 1'b0;
    check("tie_adv", 32'(strobes), 32'(X_LINK));
    check("tie_te", 32'(timeout_err), 32'd0);
    draw_step(1, X_LINK);
    draw_step(2, X_EN);
    check("r2_fc", 32'(frame_count), 32'd2);

    // Enemy engine hangs; fault bit is sticky over later frames.
    logic_steps();
    draw_step(0, X_MAP);
    draw_step(1, X_LINK);
    timeout_draw(X_EN);
    check("ento_idle", 32'(strobes), 32'(X_IDLE));
    check("ento_te", 32'(timeout_err), 32'b100);
    check("r3_fc", 32'(frame_count), 32'd3);
    for (int i = 0; i < 3; i++) run_frame();
    check("sticky_te", 32'(timeout_err), 32'b100);
    check("r6_fc", 32'(frame_count), 32'd6);

    // 250 more frames wraps the 8-bit counter to zero.
    for (int i = 0; i < 250; i++) run_frame();
    check("wrap_fc", 32'(frame_count), 32'd0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Top-level control FSM for the game datapath.
- Each frame it sequences one pass of: idle wait → move generation → collision check → apply Link action → move enemies → draw map → draw Link → draw enemies.
- It drives one-hot state strobes into the datapath and consumes its done flags.
- A per-draw watchdog keeps the frame loop alive if a draw engine hangs. Frame count and fault status are exported for debug LEDs/HEX.

Parameters:
- INIT_CYCLES, 4, cycles init is held after reset release (≥1).
- DRAW_TIMEOUT, 20'd131071, max cycles spent in any draw state before forced advance.
- FC_W, 8, frame counter width.

Ports:
- clock  in  1  system clock (CLOCK_50)
- resetn  in  1  synchronous reset, active-low
- pause  in  1  level; freezes frame progression at IDLE
- idle_done  in  1  frame-tick pulse from datapath
- draw_map_done  in  1  map draw complete
- draw_link_done  in  1  Link draw complete
- draw_enemies_done  in  1  enemy draw complete
- init  out  1  strobe, INIT state
- idle  out  1  strobe, IDLE state
- gen_move  out  1  strobe, GEN_MOVE
- check_collide  out  1  strobe, CHECK
- apply_act_link  out  1  strobe, APPLY
- move_enemies  out  1  strobe, MOVE_E
- draw_map  out  1  strobe, DRAW_MAP
- draw_link  out  1  strobe, DRAW_LINK
- draw_enemies  out  1  strobe, DRAW_E
- frame_count  out  FC_W  completed frames, wraps
- timeout_err  out  3  sticky {enemies, link, map} watchdog fault flags

Behaviour:
- Clocking and reset: all state is updated on posedge clock. While resetn=0 at an edge: state=INIT, init_cnt=0, wd_cnt=0, frame_count=0, timeout_err=0.
- Output encoding: outputs are Moore, decoded from registered state. Exactly one of the nine strobes is high in every cycle. During reset, init=1 and all other strobes are 0.
- INIT: hold for INIT_CYCLES cycles after reset deasserts, then go to DRAW_MAP. The first frame paints the screen before any movement.
- IDLE: if idle_done=1 and pause=0, go to GEN_MOVE. Otherwise stay. idle_done while paused is dropped; it is not latched.
- Single-cycle states: GEN_MOVE → CHECK → APPLY → MOVE_E → DRAW_MAP, each exactly one cycle.
- Draw states (DRAW_MAP → DRAW_LINK → DRAW_E → IDLE):
  - wd_cnt clears on entry to each draw state.
  - The done input is sampled only when wd_cnt ≥ 1. A done still high from the previous enable is ignored in the entry cycle.
  - Advance when sampled done=1, or when wd_cnt == DRAW_TIMEOUT−1. On timeout, set the matching timeout_err bit; the bit is sticky until reset.
  - Done and timeout in the same cycle: advance, and do not set the error bit.
- Frame count: frame_count increments by 1 on the DRAW_E → IDLE transition only, and wraps modulo 2^FC_W. The transition INIT → DRAW_MAP → … → IDLE also counts.
- Latency:
  - idle_done pulse → gen_move high on the next cycle.
  - Fully responsive draws (done on the first sampled cycle): 4 logic cycles + 3×2 draw cycles, then back in IDLE.
- Pause: only affects IDLE. If pause rises mid-frame, the current frame completes.
- Done inputs outside their own draw state are ignored.
- Reset mid-frame: on the next edge with resetn=0, return to INIT with counters cleared. No strobe other than init is high in that cycle.
- Illegal state encoding: recover to INIT on the next edge.
- Widths: wd_cnt is 20 bits with saturating compare. init_cnt is $clog2(INIT_CYCLES+1) bits.

Decomposition:
- Shared package game_pkg:
  - state enum (S_INIT, S_IDLE, S_GEN_MOVE, S_CHECK, S_APPLY, S_MOVE_E, S_DRAW_MAP, S_DRAW_LINK, S_DRAW_E), 4-bit encoding;
  - ON/OFF constants;
  - timeout_err bit indices (TE_MAP=0, TE_LINK=1, TE_ENEMY=2).
- One sub-module: draw_watchdog (count, clear-on-entry, timeout pulse), instantiated once and shared across the three draw states.

Test Plan:
- Reset release, INIT_CYCLES=4: init high for 4 cycles. Then draw_map=1. Drive each done 1 cycle after its enable → idle=1 at the expected cycle, frame_count=1.
- In IDLE, pulse idle_done, all dones respond on the first sampled cycle → strobes follow GEN_MOVE, CHECK, APPLY, MOVE_E, DRAW_MAP(2), DRAW_LINK(2), DRAW_E(2) exactly. frame_count 1→2.
- Hold draw_link_done=1 continuously → the entry cycle does not advance. Advance happens after 2 cycles in DRAW_LINK, not 1.
- draw_enemies_done never asserted, DRAW_TIMEOUT=16 → DRAW_E lasts 16 cycles, timeout_err=3'b100, return to IDLE. The bit persists through 3 later normal frames.
- pause=1, pulse idle_done 5 times → stays IDLE, frame_count unchanged. Drop pause, pulse once → frame proceeds.
- Assert resetn=0 during DRAW_MAP with frame_count=7, timeout_err=3'b001 → next cycle init=1, frame_count=0, timeout_err=0. One-hot strobe check holds for every cycle of the run.
